mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_sel.sv | 57 +++++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
// Holds the response-owner encoding, the default geometry of the SRAM port
// and the fetch starvation limit, and a helper that sizes the starvation
// counter.
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT    = 12;
    localparam int DATA_W_DEFAULT    = 32;
    localparam int FETCH_GAP_DEFAULT = 4;

    // Who owns the single outstanding read response.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    // Width needed to count 0..gap inclusive; never narrower than one bit.
    function automatic int cnt_width(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Priority / starvation selection for the memory arbiter.
// The data port normally wins a conflict; after FETCH_GAP consecutive data
// grants made while the fetch port is waiting, the fetch port wins once.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   if_req      - fetch port request
//   d_req       - data port request
//   if_gnt      - fetch port selected this cycle (not gated by reset)
//   d_gnt       - data port selected this cycle (not gated by reset)
module mem_arb_sel
    import mem_arb_pkg::*;
#(
    parameter int FETCH_GAP = FETCH_GAP_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    localparam int                CNT_W   = cnt_width(FETCH_GAP);
    localparam logic [CNT_W-1:0]  GAP_MAX = CNT_W'(FETCH_GAP);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             fetch_turn;

    // NOTE: every signal written here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        fetch_turn     = (starve_cnt == GAP_MAX);
        if_gnt         = if_req && (!d_req || fetch_turn);
        d_gnt          = d_req && !if_gnt;
        starve_cnt_nxt = starve_cnt;

        // The counter only measures an unbroken wait of the fetch port.
        if (!if_req || if_gnt) begin
            starve_cnt_nxt = '0;
        end else if (d_gnt && !fetch_turn) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM.
// A fetch (read-only) port and a data (load/store) port share the SRAM;
// at most one is granted per cycle. Reads return one cycle after the grant
// through a one-entry response register that remembers the owner.
//
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   if_req, if_addr, if_flush      - fetch request, address, response cancel
//   if_gnt, if_rvalid, if_rdata    - fetch grant and read response
//   d_req, d_we, d_addr, d_wdata   - data request, store flag, address, data
//   d_gnt, d_rvalid, d_rdata       - data grant and load response
//   sram_address, sram_data,
//   sram_wren                      - SRAM command (combinational)
//   sram_q                         - registered SRAM read data
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int FETCH_GAP = FETCH_GAP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data,
    output logic              sram_wren,
    input  logic [DATA_W-1:0] sram_q
);

    logic   sel_if;
    logic   sel_d;
    owner_e owner_q;
    owner_e owner_nxt;

    mem_arb_sel #(
        .FETCH_GAP (FETCH_GAP)
    ) u_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (sel_if),
        .d_gnt  (sel_d)
    );

    // A fetch granted under flush still uses the SRAM, but its response is
    // never recorded. Stores record nothing.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (sel_if && !if_flush) begin
            owner_nxt = OWN_IF;
        end else if (sel_d && !d_we) begin
            owner_nxt = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_nxt;
        end
    end

    // NOTE: reset gates the grants only on the way to the ports; the raw
    // grants feed the flops, so rst_n never enters a flop's data path while
    // the outputs still drop to zero the moment reset asserts.
    always_comb begin
        if_gnt       = rst_n && sel_if;
        d_gnt        = rst_n && sel_d;
        sram_wren    = d_gnt && d_we;
        sram_address = '0;
        if (if_gnt) begin
            sram_address = if_addr;
        end else if (d_gnt) begin
            sram_address = d_addr;
        end
        sram_data    = sram_wren ? d_wdata : '0;

        // The flush in the response cycle also kills a fetch already recorded.
        if_rvalid    = (owner_q == OWN_IF) && !if_flush;
        d_rvalid     = (owner_q == OWN_D);
        if_rdata     = if_rvalid ? sram_q : '0;
        d_rdata      = d_rvalid  ? sram_q : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the
// arbitration rules and an independent shadow copy of the SRAM contents.
module tb_mem_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int GAP = 4;

    localparam int R_NONE = 0;
    localparam int R_IF   = 1;
    localparam int R_D    = 2;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_data;
    logic          sram_wren;
    logic [DW-1:0] sram_q;

    mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .FETCH_GAP (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .sram_address (sram_address),
        .sram_data    (sram_data),
        .sram_wren    (sram_wren),
        .sram_q       (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM environment: registered read, write on wren.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_wren) sram_mem[sram_address] <= sram_data;
        sram_q <= sram_mem[sram_address];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_starve;
    int            m_resp;
    logic [DW-1:0] m_data;
    logic          m_last_if;
    logic          m_last_d;

    int tests_run;
    int tests_failed;

    // Random requester state.
    logic          r_ip;
    logic [AW-1:0] r_ia;
    logic          r_dp;
    logic          r_dw;
    logic [AW-1:0] r_da;
    logic [DW-1:0] r_dwd;
    logic          r_fl;
    int            n_gnt;
    int            n_rv;
    int            dcnt;
    int            icnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_gnt"},    64'(if_gnt),       64'd0);
        check({tag, "_if_rvalid"}, 64'(if_rvalid),    64'd0);
        check({tag, "_if_rdata"},  64'(if_rdata),     64'd0);
        check({tag, "_d_gnt"},     64'(d_gnt),        64'd0);
        check({tag, "_d_rvalid"},  64'(d_rvalid),     64'd0);
        check({tag, "_d_rdata"},   64'(d_rdata),      64'd0);
        check({tag, "_sram_addr"}, 64'(sram_address), 64'd0);
        check({tag, "_sram_data"}, 64'(sram_data),    64'd0);
        check({tag, "_sram_wren"}, 64'(sram_wren),    64'd0);
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, then
    // advance the model to what the next rising edge should produce.
    task automatic cycle(input logic ir, input logic [AW-1:0] ia, input logic fl,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd);
        logic          eg_if;
        logic          eg_d;
        logic [AW-1:0] e_addr;
        logic          e_irv;
        logic          e_drv;
        @(negedge clk);
        if_req   = ir;
        if_addr  = ia;
        if_flush = fl;
        d_req    = dr;
        d_we     = dw;
        d_addr   = da;
        d_wdata  = dwd;
        #1;
        // Data wins a conflict unless the fetch port has waited GAP grants.
        eg_if  = ir && (!dr || m_starve == GAP);
        eg_d   = dr && !eg_if;
        e_addr = eg_if ? ia : (eg_d ? da : '0);
        e_irv  = (m_resp == R_IF) && !fl;
        e_drv  = (m_resp == R_D);
        check("if_gnt",       64'(if_gnt),       64'(eg_if));
        check("d_gnt",        64'(d_gnt),        64'(eg_d));
        check("sram_address", 64'(sram_address), 64'(e_addr));
        check("sram_wren",    64'(sram_wren),    64'(eg_d && dw));
        check("sram_data",    64'(sram_data),    64'((eg_d && dw) ? dwd : '0));
        check("if_rvalid",    64'(if_rvalid),    64'(e_irv));
        check("if_rdata",     64'(if_rdata),     64'(e_irv ? m_data : '0));
        check("d_rvalid",     64'(d_rvalid),     64'(e_drv));
        check("d_rdata",      64'(d_rdata),      64'(e_drv ? m_data : '0));

        m_last_if = eg_if;
        m_last_d  = eg_d;
        if (!ir || eg_if)                 m_starve = 0;
        else if (eg_d && m_starve < GAP)  m_starve = m_starve + 1;
        m_resp = R_NONE;
        if (eg_if && !fl) begin
            m_resp = R_IF;
            m_data = ref_mem[ia];
        end else if (eg_d && !dw) begin
            m_resp = R_D;
            m_data = ref_mem[da];
        end
        if (eg_d && dw) ref_mem[da] = dwd;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_starve     = 0;
        m_resp       = R_NONE;
        m_data       = '0;
        m_last_if    = 1'b0;
        m_last_d     = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = 32'h2404_0001 + DW'(i);
            ref_mem[i]  = 32'h2404_0001 + DW'(i);
        end

        // Reset with both ports requesting: everything must stay at zero.
        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 12'h003;
        if_flush = 1'b0;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_addr   = 12'h004;
        d_wdata  = 32'h1234_5678;
        #3;
        check_all_zero("por");
        @(posedge clk);
        #2;
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        rst_n  = 1'b1;

        // Single fetch of word 5, granted in the first cycle after reset.
        cycle(1'b1, 12'h005, 1'b0, 1'b0, 1'b0, '0, '0);
        check("fetch_gnt_cycle0", 64'(if_gnt), 64'd1);
        idle();
        check("fetch_rdata_cycle1", 64'(if_rdata), 64'h2404_0006);
        check("fetch_no_d_rvalid", 64'(d_rvalid), 64'd0);

        // Store then load of the same word.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF);
        check("store_wren", 64'(sram_wren), 64'd1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 12'h010, '0);
        check("load_wren", 64'(sram_wren), 64'd0);
        check("store_no_rvalid", 64'(d_rvalid), 64'd0);
        idle();
        check("load_rdata", 64'(d_rdata), 64'hDEAD_BEEF);

        // Both ports held busy: D,D,D,D,IF repeating.
        dcnt = 0;
        icnt = 0;
        for (int k = 0; k < 15; k++) begin
            cycle(1'b1, AW'(12'h020 + icnt), 1'b0, 1'b1, 1'b0, AW'(12'h040 + dcnt), '0);
            check("gap_pattern", 64'(if_gnt), 64'((k % 5) == 4));
            if ((k % 5) == 4) icnt++;
            else              dcnt++;
        end
        idle();

        // Flush kills the previous fetch's response and the flush-cycle fetch.
        cycle(1'b1, 12'h007, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 12'h008, 1'b1, 1'b0, 1'b0, '0, '0);
        check("flush_same_cycle", 64'(if_rvalid), 64'd0);
        check("flush_cycle_gnt",  64'(if_gnt),    64'd1);
        idle();
        check("flush_cancelled", 64'(if_rvalid), 64'd0);

        // Reset right after a load grant drops the response.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 12'h003, '0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        m_resp   = R_NONE;
        m_starve = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        d_req = 1'b0;
        cycle(1'b1, 12'h002, 1'b0, 1'b0, 1'b0, '0, '0);
        check("post_reset_d_rvalid", 64'(d_rvalid), 64'd0);
        check("post_reset_first_gnt", 64'(if_gnt), 64'd1);
        idle();

        // Eight back-to-back fetches with no bubbles.
        n_gnt = 0;
        n_rv  = 0;
        for (int a = 0; a < 8; a++) begin
            cycle(1'b1, AW'(a), 1'b0, 1'b0, 1'b0, '0, '0);
            if (if_gnt)    n_gnt++;
            if (if_rvalid) n_rv++;
        end
        idle();
        if (if_rvalid) n_rv++;
        check("burst_gnt_count",    64'(n_gnt), 64'd8);
        check("burst_rvalid_count", 64'(n_rv),  64'd8);

        // Randomized traffic; requesters hold their request until granted.
        r_ip = 1'b0;
        r_dp = 1'b0;
        r_ia = '0;
        r_da = '0;
        r_dw = 1'b0;
        r_dwd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!r_ip) begin
                r_ip = ($urandom_range(0, 3) != 0);
                r_ia = AW'($urandom_range(0, 31));
            end
            if (!r_dp) begin
                r_dp  = ($urandom_range(0, 3) != 0);
                r_dw  = ($urandom_range(0, 2) == 0);
                r_da  = AW'($urandom_range(0, 31));
                r_dwd = $urandom;
            end
            r_fl = ($urandom_range(0, 7) == 0);
            cycle(r_ip, r_ia, r_fl, r_dp, r_dw, r_da, r_dwd);
            if (m_last_if) r_ip = 1'b0;
            if (m_last_d)  r_dp = 1'b0;
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
